// File: rtl/parking_request_ctrl.sv
// Parking lot request front end: debounces the entry/exit buttons, tracks occupancy and
// issues one-tick press requests to the downstream sequencer, with a lockout while it runs.
module parking_request_ctrl #(
    parameter int unsigned DEBOUNCE_MS   = 20,
    parameter int unsigned CAPACITY      = 9,
    parameter int unsigned ENTRY_BUSY_MS = 2000,
    parameter int unsigned EXIT_BUSY_MS  = 4000
) (
    input  logic       ms,
    input  logic       rst_n,
    input  logic       btn_in,
    input  logic       btn_out,
    output logic       press,
    output logic       isOut,
    output logic [3:0] free_slots,
    output logic       lot_full,
    output logic       lot_empty,
    output logic       busy,
    output logic       reject
);

    localparam int unsigned CW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);
    localparam logic [3:0] CAP4 = 4'(CAPACITY);
    localparam logic [11:0] ENTRY_LOAD = 12'(ENTRY_BUSY_MS);
    localparam logic [11:0] EXIT_LOAD = 12'(EXIT_BUSY_MS);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // Bit 0 is the entry button, bit 1 the exit button.
    logic [1:0]         raw;
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         deb;
    logic [1:0][CW-1:0] cnt;
    logic [1:0]         rise;

    logic        state_q, state_d;
    logic [11:0] timer_q, timer_d;
    logic        press_d, reject_d, isout_d, busy_d;
    logic [3:0]  free_d;

    assign raw = {btn_out, btn_in};

    always_ff @(posedge ms or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge ms or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Event strobe is taken on the tick the debounced level is about to rise, so the
    // press lands on the same edge as the debounced flip (2 + DEBOUNCE_MS ticks total).
    always_comb begin
        rise = '0;
        for (int i = 0; i < 2; i++) begin
            rise[i] = sync2[i] & ~deb[i] & (cnt[i] == CNT_LAST);
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        press_d  = 1'b0;
        reject_d = 1'b0;
        isout_d  = isOut;
        free_d   = free_slots;
        busy_d   = busy;
        case (state_q)
            ST_IDLE: begin
                // Exit has priority; a simultaneous entry is silently dropped.
                if (rise[1]) begin
                    if (free_slots < CAP4) begin
                        press_d = 1'b1;
                        isout_d = 1'b1;
                        free_d  = free_slots + 4'd1;
                        busy_d  = 1'b1;
                        timer_d = EXIT_LOAD;
                        state_d = ST_BUSY;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (rise[0]) begin
                    if (free_slots != 4'd0) begin
                        press_d = 1'b1;
                        isout_d = 1'b0;
                        free_d  = free_slots - 4'd1;
                        busy_d  = 1'b1;
                        timer_d = ENTRY_LOAD;
                        state_d = ST_BUSY;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (|rise) begin
                    reject_d = 1'b1;
                end
                if (timer_q == 12'd0) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 12'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ms or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            press      <= 1'b0;
            reject     <= 1'b0;
            isOut      <= 1'b0;
            busy       <= 1'b0;
            free_slots <= CAP4;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            press      <= press_d;
            reject     <= reject_d;
            isOut      <= isout_d;
            busy       <= busy_d;
            free_slots <= free_d;
        end
    end

    assign lot_full  = (free_slots == 4'd0);
    assign lot_empty = (free_slots == CAP4);

endmodule

// File: tb/tb_parking_request_ctrl.sv
// Bench for parking_request_ctrl: directed scenarios plus random button activity, all
// checked tick by tick against a history-based behavioural model.
module tb_parking_request_ctrl;

    localparam int DEB = 20;
    localparam int CAP = 9;
    localparam int ENT = 2000;
    localparam int EXT = 4000;
    localparam int HMAX = 131072;

    logic       ms = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_in = 1'b0;
    logic       btn_out = 1'b0;
    logic       press, isOut, lot_full, lot_empty, busy, reject;
    logic [3:0] free_slots;

    int errors = 0;
    int checks = 0;

    parking_request_ctrl #(
        .DEBOUNCE_MS  (DEB),
        .CAPACITY     (CAP),
        .ENTRY_BUSY_MS(ENT),
        .EXIT_BUSY_MS (EXT)
    ) dut (
        .ms        (ms),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .btn_out   (btn_out),
        .press     (press),
        .isOut     (isOut),
        .free_slots(free_slots),
        .lot_full  (lot_full),
        .lot_empty (lot_empty),
        .busy      (busy),
        .reject    (reject)
    );

    always #5 ms = ~ms;

    // Model: raw samples by tick number; a level is accepted once the last DEB synced
    // samples all disagree with it. Lockout is a tick deadline, not a countdown.
    logic [1:0] rawhist [0:HMAX-1];
    int  t = 0;
    int  rst_t = 0;
    int  busy_end = 0;
    int  m_free = CAP;
    bit  m_isout = 0, m_press = 0, m_reject = 0;
    bit  m_deb [2];

    task automatic model_reset();
        rst_t    = t;
        busy_end = 0;
        m_free   = CAP;
        m_isout  = 0;
        m_press  = 0;
        m_reject = 0;
        m_deb[0] = 0;
        m_deb[1] = 0;
    endtask

    task automatic model_step(input bit bi, input bit bo);
        bit ev [2];
        bit all;
        bit s;
        t++;
        rawhist[t] = {bo, bi};
        for (int b = 0; b < 2; b++) begin
            all = 1;
            for (int j = t - DEB + 1; j <= t; j++) begin
                s = (j - 2 > rst_t) ? rawhist[j-2][b] : 1'b0;
                if (s == m_deb[b]) all = 0;
            end
            ev[b] = 0;
            if (all) begin
                m_deb[b] = !m_deb[b];
                ev[b] = m_deb[b];
            end
        end
        m_press = 0;
        m_reject = 0;
        if (t <= busy_end) begin
            if (ev[0] || ev[1]) m_reject = 1;
        end else if (ev[1]) begin
            if (m_free < CAP) begin
                m_press = 1; m_isout = 1; m_free++; busy_end = t + EXT + 1;
            end else m_reject = 1;
        end else if (ev[0]) begin
            if (m_free > 0) begin
                m_press = 1; m_isout = 0; m_free--; busy_end = t + ENT + 1;
            end else m_reject = 1;
        end
    endtask

    // Drive the buttons for n ticks, comparing every output with the model each tick.
    task automatic hold(input string tag, input bit bi, input bit bo, input int n,
                        output int first_press, output int press_cnt,
                        output int reject_cnt, output int busy_cnt);
        logic [9:0] got, exp;
        first_press = 0; press_cnt = 0; reject_cnt = 0; busy_cnt = 0;
        for (int k = 1; k <= n; k++) begin
            btn_in = bi;
            btn_out = bo;
            @(posedge ms);
            model_step(bi, bo);
            #1;
            got = {press, reject, isOut, busy, free_slots, lot_full, lot_empty};
            exp = {m_press, m_reject, m_isout, (t < busy_end), 4'(m_free),
                   (m_free == 0), (m_free == CAP)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s tick %0d: got %b want %b (press,rej,isOut,busy,free,full,empty)",
                         tag, k, got, exp);
            end
            if (press === 1'b1) begin
                press_cnt++;
                if (first_press == 0) first_press = k;
            end
            if (reject === 1'b1) reject_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic do_reset();
        btn_in = 0;
        btn_out = 0;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge ms);
        #1 rst_n = 1'b1;
    endtask

    task automatic enter_one(input string tag);
        int fp, pc, rc, bc;
        hold(tag, 1, 0, 25, fp, pc, rc, bc);
        checks++;
        if (pc !== 1) begin
            errors++;
            $display("FAIL %s_press got %0d pulses want 1", tag, pc);
        end
        hold(tag, 0, 0, 2010, fp, pc, rc, bc);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge ms);
        #1;
        checks++;
        if ({free_slots, lot_empty, lot_full, busy, press, reject, isOut} !== {4'd9, 6'b100000})
        begin
            errors++;
            $display("FAIL reset_state got free=%0d empty=%b full=%b busy=%b press=%b want 9 1 0 0 0",
                     free_slots, lot_empty, lot_full, busy, press);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_glitch();
        int fp, pc, rc, bc1, bc2;
        hold("glitch", 1, 0, 10, fp, pc, rc, bc1);
        checks++;
        if (pc !== 0) begin
            errors++;
            $display("FAIL glitch_ignored got %0d presses want 0", pc);
        end
        hold("glitch_gap", 0, 0, 30, fp, pc, rc, bc1);
        hold("clean", 1, 0, 30, fp, pc, rc, bc1);
        checks++;
        if (fp !== 22 || pc !== 1) begin
            errors++;
            $display("FAIL entry_latency got tick %0d count %0d want tick 22 count 1", fp, pc);
        end
        checks++;
        if (isOut !== 1'b0 || free_slots !== 4'd8) begin
            errors++;
            $display("FAIL entry_result got isOut=%b free=%0d want 0 8", isOut, free_slots);
        end
        hold("entry_lockout", 0, 0, 2100, fp, pc, rc, bc2);
        checks++;
        if (bc1 + bc2 !== 2001) begin
            errors++;
            $display("FAIL entry_busy_len got %0d want 2001", bc1 + bc2);
        end
    endtask

    task automatic test_fill();
        int fp, pc, rc, bc;
        for (int i = 0; i < 8; i++) enter_one("fill");
        checks++;
        if (free_slots !== 4'd0 || lot_full !== 1'b1) begin
            errors++;
            $display("FAIL lot_full got free=%0d full=%b want 0 1", free_slots, lot_full);
        end
        hold("full_entry", 1, 0, 25, fp, pc, rc, bc);
        checks++;
        if (rc !== 1 || pc !== 0 || free_slots !== 4'd0) begin
            errors++;
            $display("FAIL full_reject got rej=%0d press=%0d free=%0d want 1 0 0", rc, pc, free_slots);
        end
        hold("full_release", 0, 0, 25, fp, pc, rc, bc);
    endtask

    task automatic test_exit();
        int fp, pc, rc, bc1, bc2, bc3;
        do_reset();
        enter_one("one_car");
        hold("exit", 0, 1, 25, fp, pc, rc, bc1);
        checks++;
        if (fp !== 22 || isOut !== 1'b1 || free_slots !== 4'd9) begin
            errors++;
            $display("FAIL exit_accept got tick=%0d isOut=%b free=%0d want 22 1 9", fp, isOut, free_slots);
        end
        hold("entry_in_lockout", 1, 1, 30, fp, pc, rc, bc2);
        checks++;
        if (rc !== 1 || pc !== 0 || free_slots !== 4'd9) begin
            errors++;
            $display("FAIL lockout_reject got rej=%0d press=%0d free=%0d want 1 0 9", rc, pc, free_slots);
        end
        hold("exit_lockout", 0, 0, 4100, fp, pc, rc, bc3);
        checks++;
        if (bc1 + bc2 + bc3 !== 4001) begin
            errors++;
            $display("FAIL exit_busy_len got %0d want 4001", bc1 + bc2 + bc3);
        end
    endtask

    task automatic test_empty_and_simultaneous();
        int fp, pc, rc, bc;
        hold("empty_exit", 0, 1, 25, fp, pc, rc, bc);
        checks++;
        if (rc !== 1 || pc !== 0 || free_slots !== 4'd9) begin
            errors++;
            $display("FAIL empty_exit got rej=%0d press=%0d free=%0d want 1 0 9", rc, pc, free_slots);
        end
        hold("empty_release", 0, 0, 25, fp, pc, rc, bc);
        for (int i = 0; i < 3; i++) enter_one("three_cars");
        hold("both", 1, 1, 25, fp, pc, rc, bc);
        checks++;
        if (pc !== 1 || rc !== 0 || isOut !== 1'b1 || free_slots !== 4'd7) begin
            errors++;
            $display("FAIL simultaneous got press=%0d rej=%0d isOut=%b free=%0d want 1 0 1 7",
                     pc, rc, isOut, free_slots);
        end
        hold("both_release", 0, 0, 4100, fp, pc, rc, bc);
    endtask

    task automatic test_reset_mid_busy();
        int fp, pc, rc, bc;
        enter_one("pre_reset");
        hold("pre_reset_busy", 1, 0, 25, fp, pc, rc, bc);
        hold("pre_reset_busy2", 0, 0, 100, fp, pc, rc, bc);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || free_slots !== 4'd9 || lot_empty !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got busy=%b free=%0d empty=%b want 0 9 1",
                     busy, free_slots, lot_empty);
        end
        model_reset();
        repeat (2) @(posedge ms);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_random();
        int fp, pc, rc, bc;
        int total = 0;
        while (total < 9000) begin
            int len = $urandom_range(1, 45);
            hold("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), len,
                 fp, pc, rc, bc);
            total += len;
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_fill();
        test_exit();
        test_empty_and_simultaneous();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
